// File: rtl/conv_patch_scheduler_pkg.sv
// rtl/conv_patch_scheduler_pkg.sv - shared conv types, image defaults, FSM encoding and address helper
package conv_patch_scheduler_pkg;

  localparam int CONV_IMG_W = 28;
  localparam int CONV_IMG_H = 28;
  localparam int ADDR_W     = 10;
  localparam int COORD_W    = 5;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FETCH,
    ST_MAC,
    ST_STEP,
    ST_FIN
  } state_t;

  // Address of tap k of a row-major 3x3 patch; wraps at the pixel memory size.
  function automatic addr_t patch_addr(input addr_t base, input coord_t row, input coord_t col,
                                       input int k, input int img_w);
    logic [31:0] sum;
    sum = 32'(base) + 32'((int'(row) + k / 3) * img_w) + 32'(col) + 32'(k % 3);
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/conv_patch_scheduler_if.sv
// rtl/conv_patch_scheduler_if.sv - scheduler control, patch latch and MAC handshake bundle
interface conv_patch_scheduler_if;
  import conv_patch_scheduler_pkg::*;

  logic   start;
  addr_t  img_base;
  logic   load;
  logic   load_full_patch;
  addr_t  pixel_addr0, pixel_addr1, pixel_addr2;
  addr_t  pixel_addr3, pixel_addr4, pixel_addr5;
  addr_t  pixel_addr6, pixel_addr7, pixel_addr8;
  logic   load_done;
  logic   mac_start;
  logic   mac_done;
  coord_t out_row;
  coord_t out_col;
  logic   busy;
  logic   done;

  modport master (
    input  start, img_base, load_done, mac_done,
    output load, load_full_patch,
           pixel_addr0, pixel_addr1, pixel_addr2,
           pixel_addr3, pixel_addr4, pixel_addr5,
           pixel_addr6, pixel_addr7, pixel_addr8,
           mac_start, out_row, out_col, busy, done
  );

  modport slave (
    output start, img_base, load_done, mac_done,
    input  load, load_full_patch,
           pixel_addr0, pixel_addr1, pixel_addr2,
           pixel_addr3, pixel_addr4, pixel_addr5,
           pixel_addr6, pixel_addr7, pixel_addr8,
           mac_start, out_row, out_col, busy, done
  );

endinterface

// File: rtl/conv_patch_scheduler_patch_addr_gen.sv
// rtl/conv_patch_scheduler_patch_addr_gen.sv - combinational nine-tap patch address generator
import conv_patch_scheduler_pkg::*;

module patch_addr_gen #(
  parameter int IMG_W = CONV_IMG_W
) (
  input  addr_t  base,
  input  coord_t row,
  input  coord_t col,
  output addr_t  addr [9]
);

  for (genvar k = 0; k < 9; k++) begin : g_tap
    assign addr[k] = patch_addr(base, row, col, k, IMG_W);
  end

endmodule

// File: rtl/conv_patch_scheduler.sv
// rtl/conv_patch_scheduler.sv - column-major 3x3 patch scan sequencing patch latch and MAC
import conv_patch_scheduler_pkg::*;

module conv_patch_scheduler #(
  parameter int IMG_W = CONV_IMG_W,
  parameter int IMG_H = CONV_IMG_H
) (
  input  logic                   clk,
  input  logic                   rst,
  conv_patch_scheduler_if.master bus
);

  localparam coord_t ROW_LAST = coord_t'(IMG_H - 3);
  localparam coord_t COL_LAST = coord_t'(IMG_W - 3);

  state_t state_q, state_d;
  coord_t row_q, row_d, col_q, col_d;
  addr_t  base_q, base_d;
  logic   full_q, full_d;
  logic   upd;
  logic   mac_start_q, mac_start_d;
  addr_t  addr_q [9];
  addr_t  addr_d [9];

  // Fed with the next coordinates so the registered addresses change on the same edge as row/col.
  patch_addr_gen #(.IMG_W(IMG_W)) u_addr_gen (
    .base (base_d),
    .row  (row_d),
    .col  (col_d),
    .addr (addr_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    base_d      = base_q;
    full_d      = full_q;
    upd         = 1'b0;
    mac_start_d = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d = ST_ARM;
        row_d   = '0;
        col_d   = '0;
        base_d  = bus.img_base;
        full_d  = 1'b1;
        upd     = 1'b1;
      end
      // A load_done still high from the previous patch must drop before it can count.
      ST_ARM:   if (!bus.load_done) state_d = ST_FETCH;
      ST_FETCH: if (bus.load_done) begin
        state_d     = ST_MAC;
        mac_start_d = 1'b1;
      end
      ST_MAC:   if (bus.mac_done) state_d = ST_STEP;
      ST_STEP: begin
        if (row_q < ROW_LAST) begin
          row_d   = row_q + coord_t'(1);
          full_d  = 1'b0;
          upd     = 1'b1;
          state_d = ST_ARM;
        end else if (col_q < COL_LAST) begin
          row_d   = '0;
          col_d   = col_q + coord_t'(1);
          full_d  = 1'b1;
          upd     = 1'b1;
          state_d = ST_ARM;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q       <= '0;
      col_q       <= '0;
      base_q      <= '0;
      full_q      <= 1'b0;
      mac_start_q <= 1'b0;
      for (int k = 0; k < 9; k++) addr_q[k] <= '0;
    end else begin
      mac_start_q <= mac_start_d;
      base_q      <= base_d;
      if (upd) begin
        row_q  <= row_d;
        col_q  <= col_d;
        full_q <= full_d;
        addr_q <= addr_d;
      end
    end
  end

  assign bus.load            = (state_q == ST_ARM) || (state_q == ST_FETCH);
  assign bus.busy            = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign bus.done            = (state_q == ST_FIN);
  assign bus.mac_start       = mac_start_q;
  assign bus.load_full_patch = full_q;
  assign bus.out_row         = row_q;
  assign bus.out_col         = col_q;
  assign bus.pixel_addr0     = addr_q[0];
  assign bus.pixel_addr1     = addr_q[1];
  assign bus.pixel_addr2     = addr_q[2];
  assign bus.pixel_addr3     = addr_q[3];
  assign bus.pixel_addr4     = addr_q[4];
  assign bus.pixel_addr5     = addr_q[5];
  assign bus.pixel_addr6     = addr_q[6];
  assign bus.pixel_addr7     = addr_q[7];
  assign bus.pixel_addr8     = addr_q[8];

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// tb/tb_conv_patch_scheduler.sv - randomized scoreboard bench for 28x28 and 3x3 scheduler instances
module tb_conv_patch_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_patch_scheduler_if b28();
  conv_patch_scheduler_if b3();

  conv_patch_scheduler u_dut28 (.clk(clk), .rst(rst), .bus(b28));
  conv_patch_scheduler #(.IMG_W(3), .IMG_H(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;

  // 28x28 environment and scoreboard state
  int p, full_loads, mac_cnt, done_cnt, base_m;
  int ld_delay, ld_hold, mac_wait;
  bit mac_pend, resp_en;
  logic load_prev;

  function automatic logic [104:0] outs28();
    return {b28.load, b28.load_full_patch, b28.mac_start, b28.busy, b28.done,
            b28.out_row, b28.out_col,
            b28.pixel_addr0, b28.pixel_addr1, b28.pixel_addr2, b28.pixel_addr3, b28.pixel_addr4,
            b28.pixel_addr5, b28.pixel_addr6, b28.pixel_addr7, b28.pixel_addr8};
  endfunction

  function automatic logic [104:0] outs3();
    return {b3.load, b3.load_full_patch, b3.mac_start, b3.busy, b3.done,
            b3.out_row, b3.out_col,
            b3.pixel_addr0, b3.pixel_addr1, b3.pixel_addr2, b3.pixel_addr3, b3.pixel_addr4,
            b3.pixel_addr5, b3.pixel_addr6, b3.pixel_addr7, b3.pixel_addr8};
  endfunction

  task automatic clear_env28();
    p = 0; full_loads = 0; mac_cnt = 0; done_cnt = 0;
    ld_delay = 0; ld_hold = 0; mac_wait = 0; mac_pend = 0; resp_en = 1;
    load_prev = 1'b0;
    b28.start = 1'b0; b28.load_done = 1'b0; b28.mac_done = 1'b0;
  endtask

  // One cycle of the 28x28 environment: score outputs, then drive latch/MAC/start responses.
  task automatic step28();
    logic [9:0] got [9];
    int r, c, exp_a;
    @(negedge clk);
    got = '{b28.pixel_addr0, b28.pixel_addr1, b28.pixel_addr2, b28.pixel_addr3, b28.pixel_addr4,
            b28.pixel_addr5, b28.pixel_addr6, b28.pixel_addr7, b28.pixel_addr8};
    if (b28.load) begin
      n_checks++;
      if (p >= 676) begin
        n_fail++; $display("FAIL extra_load: load high after patch %0d, required none", p);
      end else begin
        r = p % 26; c = p / 26;
        if (!load_prev && b28.load_full_patch) full_loads++;
        for (int k = 0; k < 9; k++) begin
          exp_a = (base_m + (r + k / 3) * 28 + c + k % 3) % 1024;
          n_checks++;
          if (got[k] !== 10'(exp_a)) begin
            n_fail++; $display("FAIL addr%0d patch %0d: got %0d required %0d", k, p, got[k], exp_a);
          end
        end
        n_checks++;
        if ({b28.load_full_patch, b28.out_row, b28.out_col, b28.busy} !== {(r == 0), 5'(r), 5'(c), 1'b1}) begin
          n_fail++;
          $display("FAIL patch_meta %0d: full/row/col/busy got %0d/%0d/%0d/%0d required %0d/%0d/%0d/1",
                   p, b28.load_full_patch, b28.out_row, b28.out_col, b28.busy, r == 0, r, c);
        end
        if (!load_prev && base_m == 100 && p == 1) begin
          n_checks++;
          if ({b28.load_full_patch, b28.pixel_addr6, b28.out_row} !== {1'b0, 10'd184, 5'd1}) begin
            n_fail++; $display("FAIL shift_patch: full/addr6/row got %0d/%0d/%0d required 0/184/1",
                               b28.load_full_patch, b28.pixel_addr6, b28.out_row);
          end
        end
        if (!load_prev && base_m == 100 && p == 26) begin
          n_checks++;
          if ({b28.load_full_patch, b28.pixel_addr0, b28.out_row, b28.out_col} !== {1'b1, 10'd101, 5'd0, 5'd1}) begin
            n_fail++; $display("FAIL col_wrap: full/addr0/row/col got %0d/%0d/%0d/%0d required 1/101/0/1",
                               b28.load_full_patch, b28.pixel_addr0, b28.out_row, b28.out_col);
          end
        end
      end
    end
    load_prev = b28.load;
    if (b28.mac_start) begin
      mac_cnt++; p++; mac_pend = 1; mac_wait = $urandom_range(0, 3);
    end
    if (b28.done) done_cnt++;
    b28.mac_done = 1'b0;
    if (mac_pend) begin
      if (mac_wait == 0) begin b28.mac_done = 1'b1; mac_pend = 0; end
      else mac_wait--;
    end else if ($urandom_range(0, 15) == 0) begin
      b28.mac_done = 1'b1;
    end
    b28.start = b28.busy && ($urandom_range(0, 15) == 0);
    if (b28.load_done) begin
      if (ld_hold == 0) b28.load_done = 1'b0;
      else ld_hold--;
    end else if (b28.load && resp_en) begin
      if (ld_delay == 0) begin
        b28.load_done = 1'b1; ld_hold = $urandom_range(0, 4); ld_delay = $urandom_range(0, 3);
      end else ld_delay--;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (outs28() !== '0) begin
      n_fail++; $display("FAIL reset_28: outputs got %h required 0", outs28());
    end
    n_checks++;
    if (outs3() !== '0) begin
      n_fail++; $display("FAIL reset_3: outputs got %h required 0", outs3());
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({b28.load, b3.load, b28.busy, b3.busy} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: load/busy got %b required 0000",
                         {b28.load, b3.load, b28.busy, b3.busy});
    end
  endtask

  task automatic test_single_patch();
    int dcnt, mcnt;
    logic [9:0] got [9];
    @(negedge clk); b3.img_base = 10'd0; b3.start = 1'b1;
    @(negedge clk); b3.start = 1'b0;
    got = '{b3.pixel_addr0, b3.pixel_addr1, b3.pixel_addr2, b3.pixel_addr3, b3.pixel_addr4,
            b3.pixel_addr5, b3.pixel_addr6, b3.pixel_addr7, b3.pixel_addr8};
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (got[k] !== 10'(k)) begin
        n_fail++; $display("FAIL single_addr%0d: got %0d required %0d", k, got[k], k);
      end
    end
    n_checks++;
    if ({b3.load, b3.load_full_patch, b3.busy, b3.out_row, b3.out_col} !== {3'b111, 10'd0}) begin
      n_fail++; $display("FAIL single_load: load/full/busy got %b required 111", {b3.load, b3.load_full_patch, b3.busy});
    end
    repeat (2) @(negedge clk);
    b3.load_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b3.mac_start, b3.load} !== 2'b10) begin
      n_fail++; $display("FAIL single_mac_start: mac_start/load got %b required 10", {b3.mac_start, b3.load});
    end
    b3.load_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b3.mac_start !== 1'b0) begin
      n_fail++; $display("FAIL single_mac_pulse: mac_start got %b required 0", b3.mac_start);
    end
    b3.mac_done = 1'b1;
    dcnt = 0; mcnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); b3.mac_done = 1'b0;
      if (b3.done) dcnt++;
      if (b3.mac_start || b3.load) mcnt++;
    end
    n_checks++;
    if (dcnt !== 1 || mcnt !== 0 || b3.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: done pulses %0d extra load/mac %0d busy %b required 1/0/0", dcnt, mcnt, b3.busy);
    end
  endtask

  task automatic test_stale_flag();
    int bad, dcnt;
    b3.load_done = 1'b1;
    @(negedge clk); b3.img_base = 10'(($urandom_range(0, 1023))); b3.start = 1'b1;
    @(negedge clk); b3.start = 1'b0;
    bad = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (b3.load !== 1'b1 || b3.mac_start !== 1'b0) bad++;
      @(negedge clk);
    end
    b3.load_done = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (b3.load !== 1'b1 || b3.mac_start !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL stale_hold: %0d cycles with early mac_start or dropped load, required 0", bad);
    end
    b3.load_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b3.mac_start, b3.load} !== 2'b10) begin
      n_fail++; $display("FAIL stale_release: mac_start/load got %b required 10", {b3.mac_start, b3.load});
    end
    b3.load_done = 1'b0; b3.mac_done = 1'b1;
    dcnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk); b3.mac_done = 1'b0;
      if (b3.done) dcnt++;
    end
    n_checks++;
    if (dcnt !== 1) begin
      n_fail++; $display("FAIL stale_done: done pulses got %0d required 1", dcnt);
    end
  endtask

  task automatic test_full_scan(input int base);
    clear_env28();
    base_m = base;
    @(negedge clk); b28.img_base = 10'(base); b28.start = 1'b1;
    for (int cyc = 0; cyc < 40000 && done_cnt == 0; cyc++) step28();
    n_checks++;
    if (done_cnt == 0) begin
      n_fail++; $display("FAIL scan_timeout: base %0d no done after 40000 cycles, patches %0d", base, p);
    end
    repeat (6) step28();
    n_checks++;
    if (mac_cnt !== 676 || full_loads !== 26 || done_cnt !== 1 || b28.busy !== 1'b0) begin
      n_fail++; $display("FAIL scan_counts: base %0d mac %0d full %0d done %0d busy %b required 676/26/1/0",
                         base, mac_cnt, full_loads, done_cnt, b28.busy);
    end
  endtask

  task automatic test_reset_mid_scan();
    int nb;
    clear_env28();
    base_m = $urandom_range(0, 1023);
    @(negedge clk); b28.img_base = 10'(base_m); b28.start = 1'b1;
    for (int cyc = 0; cyc < 5000 && !(p >= 30 && b28.load); cyc++) step28();
    resp_en = 0; b28.load_done = 1'b0; b28.mac_done = 1'b0; b28.start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (b28.load !== 1'b1) begin
      n_fail++; $display("FAIL mid_scan_setup: load got %b required 1", b28.load);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (outs28() !== '0) begin
      n_fail++; $display("FAIL async_reset: outputs got %h required 0", outs28());
    end
    @(negedge clk); rst = 1'b1;
    nb = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (b28.load !== 1'b0) nb++;
    end
    n_checks++;
    if (nb !== 0) begin
      n_fail++; $display("FAIL no_load_after_reset: %0d cycles with load, required 0", nb);
    end
    nb = $urandom_range(0, 1023);
    b28.img_base = 10'(nb); b28.start = 1'b1;
    @(negedge clk); b28.start = 1'b0;
    n_checks++;
    if ({b28.load, b28.load_full_patch, b28.out_row, b28.out_col, b28.pixel_addr0, b28.pixel_addr8}
        !== {2'b11, 10'd0, 10'(nb), 10'((nb + 58) % 1024)}) begin
      n_fail++; $display("FAIL restart: load/full/row/col/a0/a8 got %0d/%0d/%0d/%0d/%0d/%0d required 1/1/0/0/%0d/%0d",
                         b28.load, b28.load_full_patch, b28.out_row, b28.out_col, b28.pixel_addr0,
                         b28.pixel_addr8, nb, (nb + 58) % 1024);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    b3.start = 1'b0; b3.img_base = '0; b3.load_done = 1'b0; b3.mac_done = 1'b0;
    clear_env28();
    b28.img_base = '0;
    test_reset();
    test_single_patch();
    test_stale_flag();
    test_full_scan(100);
    test_reset_mid_scan();
    test_full_scan($urandom_range(900, 1023));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_patch_scheduler.md
CONV_PATCH_SCHEDULER -- requirements
Module: conv_patch_scheduler

Interface
REQ-001 Parameter IMG_W, default 28, input image width in pixels.
REQ-002 Parameter IMG_H, default 28, input image height in pixels.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a full-image scan; ignored unless idle.
REQ-006 img_base  input  10  base address of image in pixel memory; sampled on accepted start.
REQ-007 load  output  1  request to patch latch to fetch a patch.
REQ-008 load_full_patch  output  1  1 = fetch all 9 pixels; 0 = shift up one row and fetch new bottom row.
REQ-009 pixel_addr0..pixel_addr8  output  10 each  row-major 3x3 patch addresses (0..2 top row, 6..8 bottom row).
REQ-010 load_done  input  1  patch latch completion flag.
REQ-011 mac_start  output  1  one-cycle pulse; patch registers valid, start MAC.
REQ-012 mac_done  input  1  one-cycle pulse; MAC result consumed.
REQ-013 out_row, out_col  output  5 each  output-map coordinates of the current patch.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the last patch's mac_done.

Function
REQ-016 Scan order SHALL be column-major: for col 0..IMG_W-3, rows 0..IMG_H-3 in sequence.
REQ-017 load_full_patch SHALL be 1 for row 0 of every column and 0 for all other rows.
REQ-018 pixel_addrK SHALL equal img_base + (row + K/3)*IMG_W + col + (K mod 3), computed modulo 1024.
REQ-019 Addresses, load_full_patch, out_row and out_col SHALL be registered and SHALL stay stable while load is high.
REQ-020 FSM states: IDLE, ARM, FETCH, MAC, STEP, FIN.
REQ-021 IDLE: on start go to ARM with row=col=0; outputs are updated on the same edge.
REQ-022 ARM: load=1; leave for FETCH only when load_done==0, so a stale load_done from the previous patch is discarded.
REQ-023 FETCH: load=1; on load_done==1, deassert load on the next edge, pulse mac_start for exactly one cycle, then go to MAC.
REQ-024 MAC: wait for mac_done, then go to STEP; load stays 0.
REQ-025 STEP: if row<IMG_H-3 then row++. Else if col<IMG_W-3 then row=0 and col++. Else go to FIN. All non-FIN cases return to ARM.
REQ-026 FIN: pulse done for one cycle, drop busy, return to IDLE.
REQ-027 Latency for a full load is at most 7 cycles from load rise to mac_start, assuming the latch clear cycle.
REQ-028 start during busy SHALL be ignored; mac_done outside MAC SHALL be ignored.
REQ-029 mac_done and load_done arriving in the same cycle SHALL be resolved by the current state only.
REQ-030 A row-0 patch that follows a column change SHALL always use a full load, never a shift.

Reset
REQ-031 Asynchronous assertion SHALL clear outputs immediately, including mid-scan.
REQ-032 On reset: state=IDLE; row=col=0; load, load_full_patch, mac_start, busy and done = 0; all pixel_addr = 0.
REQ-033 After reset release, no load SHALL be issued until a new start.

Structure
REQ-034 IMG_W/IMG_H defaults, the 10-bit address width and the FSM state encoding SHALL live in a shared conv package.
REQ-035 A single sub-module, patch_addr_gen, SHALL compute the nine addresses combinationally from base, row and col; the parent registers the result.

Verification
REQ-036 Single patch: IMG_W=IMG_H=3, img_base=0, start. Expect one full load with addresses 0..8, one mac_start, and done after mac_done.
REQ-037 Shift: with the 28x28 default and img_base=100, the 2nd patch SHALL have load_full_patch=0, pixel_addr6=100+3*28=184, out_row=1.
REQ-038 Column wrap: after patch (row 25, col 0), the next patch SHALL be row 0, col 1, full load, pixel_addr0=101.
REQ-039 Count: a full 28x28 scan yields exactly 676 mac_start pulses and 26 full loads, with one done pulse.
REQ-040 Stale flag: hold load_done=1 when ARM is entered. Load SHALL stay high and no mac_start SHALL fire until load_done falls and then rises again.
REQ-041 Reset mid-scan while in FETCH: all outputs go 0 at once, and a subsequent start restarts at row=col=0.
